// File: rtl/mio_responder.sv
// Slave end of the CPU MemRead/MemWrite/MIO_ready handshake: decodes each word
// transaction to data RAM (with wait states), a GPIO register or a free-running counter.
module mio_responder #(
  parameter int RAM_LAT = 2,
  parameter int RAM_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic              cpu_mio,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out,
  output logic [31:0]       counter_out
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [29:0] GPIO_WORD = 30'h3C00_0000;
  localparam logic [29:0] CNT_WORD  = 30'h3C00_0001;
  localparam logic [3:0]  LAT_M1    = 4'(RAM_LAT - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [RAM_AW-1:0] cap_ram_addr;
  logic [31:0]       cap_wdata;
  logic              cap_write;
  logic              cap_ram;
  logic              cap_gpio;
  logic              cap_cnt;
  logic [31:0]       counter;

  logic req;
  logic sel_ram;
  logic sel_gpio;
  logic sel_cnt;
  logic unused_addr_lsb;

  assign req             = cpu_mio & (mem_r | mem_w);
  assign sel_ram         = (addr[31:28] != 4'hF);
  assign sel_gpio        = (addr[31:2] == GPIO_WORD);
  assign sel_cnt         = (addr[31:2] == CNT_WORD);
  assign unused_addr_lsb = &{1'b0, addr[1:0]};

  function automatic logic [31:0] io_read(input logic is_gpio, input logic is_cnt,
                                          input logic [31:0] gpio_val,
                                          input logic [31:0] cnt_val);
    if (is_gpio)     return gpio_val;
    else if (is_cnt) return cnt_val;
    else             return 32'h0;
  endfunction

  // In IDLE the RAM sees the live address so its one-cycle read latency is
  // already spent by the time the WAIT state hands rdata its value.
  assign ram_addr    = (state == IDLE) ? addr[RAM_AW+1:2] : cap_ram_addr;
  assign ram_din     = cap_wdata;
  assign ram_we      = (state == ACK) & cap_ram & cap_write;
  assign mio_ready   = (state == ACK);
  assign counter_out = counter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cap_ram_addr <= '0;
      cap_wdata    <= 32'h0;
      cap_write    <= 1'b0;
      cap_ram      <= 1'b0;
      cap_gpio     <= 1'b0;
      cap_cnt      <= 1'b0;
      rdata        <= 32'h0;
      gpio_out     <= 32'h0;
      counter      <= 32'h0;
    end else begin
      counter <= counter + 32'd1;
      case (state)
        IDLE: begin
          if (req) begin
            cap_ram_addr <= addr[RAM_AW+1:2];
            cap_wdata    <= wdata;
            cap_write    <= mem_w;
            cap_ram      <= sel_ram;
            cap_gpio     <= sel_gpio;
            cap_cnt      <= sel_cnt;
            if (sel_ram) begin
              state    <= WAIT;
              wait_cnt <= LAT_M1;
            end else begin
              state <= ACK;
              if (!mem_w) rdata <= io_read(sel_gpio, sel_cnt, gpio_in, counter);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ACK;
            if (!cap_write) rdata <= ram_dout;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          // IO writes commit as ACK ends; a counter load overrides the increment.
          if (cap_write && !cap_ram) begin
            if (cap_gpio) gpio_out <= cap_wdata;
            if (cap_cnt)  counter  <= cap_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder with a behavioural synchronous RAM model.
module tb_mio_responder;
  localparam int RAM_LAT = 2;
  localparam int RAM_AW  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_r, mem_w, cpu_mio;
  logic [31:0]       addr, wdata, rdata;
  logic              mio_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_din, ram_dout;
  logic [31:0]       gpio_in, gpio_out, counter_out;

  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic              pre_en = 1'b0;
  logic [RAM_AW-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int rdy_cnt = 0;

  mio_responder #(.RAM_LAT(RAM_LAT), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .counter_out(counter_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (mio_ready) rdy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts just after a rising edge; lat is the cycle index of the ack (-1 if none).
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic hold, output int lat, output logic [31:0] rd,
                     output int aerr);
    mem_r = ~w; mem_w = w; cpu_mio = 1'b1; addr = a; wdata = d;
    lat = -1; rd = '0; aerr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_addr !== a[RAM_AW+1:2]) aerr++;
      if (mio_ready) begin
        lat = c;
        rd = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, aerr, we0, r0;
    logic [31:0] rd, m12;
    reset = 1'b1; mem_r = 0; mem_w = 0; cpu_mio = 0;
    addr = '0; wdata = '0; gpio_in = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, mio_ready}, 32'h0);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_counter", counter_out, 32'h0);
    pre_en = 1'b1; pre_addr = 10'd4; pre_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    pre_en = 1'b0;
    reset = 1'b0;
    idle(1);

    // RAM read with wait states
    r0 = rdy_cnt;
    txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, lat, rd, aerr);
    idle(2);
    chk("ram_rd_lat", lat, RAM_LAT + 1);
    chk("ram_rd_data", rd, 32'hDEAD_BEEF);
    chk("ram_rd_addr_stable", aerr, 0);
    chk("ram_rd_pulses", rdy_cnt - r0, 1);

    // GPIO write then read
    we0 = we_cnt;
    txn(1'b1, 32'hF000_0000, 32'h0000_00A5, 1'b0, lat, rd, aerr);
    chk("gpio_wr_lat", lat, 1);
    chk("gpio_out", gpio_out, 32'h0000_00A5);
    idle(1);
    chk("gpio_wr_no_we", we_cnt - we0, 0);
    txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, lat, rd, aerr);
    chk("gpio_rd_lat", lat, 1);
    chk("gpio_rd_data", rd, 32'hCAFE_F00D);
    idle(1);

    // Counter load and wrap
    txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0, lat, rd, aerr);
    chk("cnt_wr_lat", lat, 1);
    chk("cnt_loaded", counter_out, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("cnt_max", counter_out, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("cnt_wrap", counter_out, 32'h0);
    @(posedge clk); #1;
    txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, lat, rd, aerr);
    chk("cnt_rd_lat", lat, 1);
    chk("cnt_rd_data", rd, 32'hFFFF_FFFE + 32'd3);
    idle(1);

    // Back-to-back RAM write then read of the same word
    we0 = we_cnt; r0 = rdy_cnt;
    txn(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, lat, rd, aerr);
    chk("b2b_wr_lat", lat, RAM_LAT + 1);
    txn(1'b0, 32'h0000_0020, 32'h0, 1'b0, lat, rd, aerr);
    chk("b2b_rd_lat", lat, RAM_LAT + 1);
    chk("b2b_rd_data", rd, 32'h1234_5678);
    idle(6);
    chk("b2b_we_cycles", we_cnt - we0, 1);
    chk("b2b_pulses", rdy_cnt - r0, 2);

    // Requests without cpu_mio are ignored
    we0 = we_cnt; r0 = rdy_cnt;
    mem_r = 1'b1; cpu_mio = 1'b0; addr = 32'h0000_0010;
    repeat (10) @(posedge clk);
    #1;
    idle(2);
    chk("nomio_pulses", rdy_cnt - r0, 0);
    chk("nomio_we", we_cnt - we0, 0);

    // Unmapped IO read returns 0 (rdata held 0x12345678 before)
    txn(1'b0, 32'hF000_0008, 32'h0, 1'b0, lat, rd, aerr);
    chk("unmap_lat", lat, 1);
    chk("unmap_data", rd, 32'h0);
    idle(1);
    txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, lat, rd, aerr);
    chk("pre_rst_rdata", rd, 32'hCAFE_F00D);
    idle(1);

    // Reset during WAIT of a RAM write drops it
    m12 = mem[12];
    we0 = we_cnt; r0 = rdy_cnt;
    mem_w = 1'b1; cpu_mio = 1'b1; addr = 32'h0000_0030; wdata = 32'h0000_0055;
    @(posedge clk); #2;
    reset = 1'b1;
    mem_w = 1'b0; cpu_mio = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", {31'b0, mio_ready}, 32'h0);
    chk("rst_wait_we", {31'b0, ram_we}, 32'h0);
    chk("rst_wait_rdata", rdata, 32'h0);
    chk("rst_wait_gpio", gpio_out, 32'h0);
    chk("rst_wait_counter", counter_out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    chk("rst_wait_no_we", we_cnt - we0, 0);
    chk("rst_wait_no_ack", rdy_cnt - r0, 0);
    chk("rst_wait_mem", mem[12], m12);
    txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, lat, rd, aerr);
    chk("post_rst_idle_lat", lat, 1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Memory/IO bus responder: the slave end of the CPU MemRead/MemWrite/MIO_ready handshake driven by the multicycle control unit.
- Accepts one word transaction at a time and decodes the address to data RAM, a GPIO register or a free-running counter.
- Inserts RAM wait states and returns a one-cycle mio_ready pulse per completed transaction.

Parameters:
- RAM_LAT, 2, RAM wait cycles before ack; legal range 1..15.
- RAM_AW, 10, RAM word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset (asynchronous, active-high)
- mem_r  in  1  CPU read request
- mem_w  in  1  CPU write request
- cpu_mio  in  1  CPU bus-cycle qualifier; requests ignored when 0
- addr  in  32  byte address (word aligned; addr[1:0] ignored)
- wdata  in  32  CPU write data
- rdata  out  32  read data to CPU
- mio_ready  out  1  transaction complete, one-cycle pulse
- ram_addr  out  RAM_AW  RAM word address
- ram_we  out  1  RAM write enable
- ram_din  out  32  RAM write data
- ram_dout  in  32  synchronous RAM read data (1-cycle latency)
- gpio_in  in  32  GPIO input pins
- gpio_out  out  32  GPIO output register
- counter_out  out  32  counter value

Behaviour:
- Reset is clk-independent; reset is asynchronous, active-high, clock clk. On reset:
  - state=IDLE; mio_ready=0, ram_we=0.
  - rdata=0, gpio_out=0, counter=0.
  - Captured request registers cleared.
  - A transaction interrupted by reset is dropped: no write committed, no ack.
- Address map:
  - addr[31:28]!=4'hF selects RAM; word = addr[RAM_AW+1:2].
  - 0xF0000000: GPIO; reads return gpio_in, writes load gpio_out.
  - 0xF0000004: counter; reads return counter, writes load counter.
  - Any other 0xF... address: reads return 0, writes ignored, still acked.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if cpu_mio & (mem_r|mem_w), capture addr, wdata and direction at the edge. Write wins if both mem_r and mem_w are set.
  - IDLE, RAM target: go to WAIT and load wait_cnt=RAM_LAT-1.
  - IDLE, IO target: go to ACK directly.
  - WAIT: decrement wait_cnt; go to ACK when wait_cnt=0. Gives RAM_LAT cycles in WAIT.
  - ACK: mio_ready=1 for exactly this cycle, then always IDLE.
  - A request present in the cycle after ACK is a new transaction. The CPU advances on the edge that samples ready, so back-to-back transactions (e.g. SW then instruction fetch) must each be served exactly once.
- Latency, with request first visible in cycle 0:
  - RAM: ack in cycle RAM_LAT+1.
  - IO: ack in cycle 1.
  - mio_ready is decoded from registered state only; no combinational path from inputs.
- RAM interface:
  - ram_addr is driven from the captured address for the whole WAIT/ACK span.
  - ram_din = captured wdata.
  - ram_we=1 only in the ACK cycle of a RAM write, giving exactly one write per transaction.
- Read data:
  - rdata is registered, loaded on the edge entering ACK.
  - RAM source: ram_dout, valid because ram_addr has been stable ≥1 cycle.
  - IO sources: gpio_in, counter, or 0 per the map.
  - rdata holds its value until the next read load; writes leave rdata unchanged.
- Write commit:
  - gpio_out and counter update on the edge ending ACK.
  - A counter load overrides that cycle's increment.
- Counter: increments by 1 every clk, wraps 0xFFFFFFFF→0. counter_out = counter.
- mem_r/mem_w deasserted while in WAIT: transaction still completes and acks; its ack is ignored by the CPU.

Test Plan:
- RAM_LAT=2, read addr 0x00000010 with RAM word 4=0xDEADBEEF:
  - mio_ready high in cycle 3 only.
  - rdata=0xDEADBEEF in cycle 3.
  - ram_addr=4 throughout.
- Write 0xF0000000 data 0x000000A5: ack in cycle 1; gpio_out=0x000000A5 from cycle 2; no ram_we.
- Read of 0xF0000004:
  - Counter load with 0xFFFFFFFE via write; next read returns load-value plus elapsed cycles.
  - Counter observed to wrap through 0.
- Back-to-back, RAM write 0x20=0x12345678 then read 0x20 held asserted in the cycle after ack:
  - ram_we exactly 1 cycle.
  - Second ack returns 0x12345678.
  - Exactly two mio_ready pulses.
- Reset asserted in WAIT of a RAM write: ram_we never asserted; mio_ready=0; state IDLE; outputs at reset values.
- cpu_mio=0 with mem_r=1 for 10 cycles: no ack, ram_we 0. Read of 0xF0000008 returns 0 with ack in cycle 1.
